// File: rtl/alu_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_fifo
// Description : Issue stage in front of the pipelined ALU. Packets of
//               {opcode, a, b} come in from a valid/ready producer and are
//               buffered in a small circular FIFO. They are then issued one
//               per cycle onto registered a/b/opcode outputs, qualified by
//               issue_valid. A downstream hold stalls issue. There is no
//               bypass, so the minimum latency is two edges.
// Ports       : clk, rst (async, active-low)
//               in_valid/in_ready/in_a/in_b/in_opcode : producer side
//               hold                                  : downstream stall
//               a/b/opcode/issue_valid                : registered issue
//               count/full/empty/issued_cnt           : status
// Revision    : 1.0  initial release
// ============================================================================
module alu_issue_fifo #(
    parameter int DW    = 4,
    parameter int OPW   = 3,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_a,
    input  logic [DW-1:0]  in_b,
    input  logic [OPW-1:0] in_opcode,
    input  logic           hold,
    output logic [DW-1:0]  a,
    output logic [DW-1:0]  b,
    output logic [OPW-1:0] opcode,
    output logic           issue_valid,
    output logic [AW:0]    count,
    output logic           full,
    output logic           empty,
    output logic [7:0]     issued_cnt
);

    localparam int          c_pw    = OPW + 2 * DW;
    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

    logic [c_pw-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;
    logic [c_pw-1:0] w_head;

    // Full and empty come from the occupancy count. Pointer comparison
    // alone cannot tell the two apart once the pointers have wrapped.
    assign count    = r_count;
    assign full     = (r_count == c_depth);
    assign empty    = (r_count == '0);
    assign in_ready = !full;

    // A pop only ever sees pre-edge contents. A packet arriving into an empty
    // FIFO therefore waits one edge, and a full FIFO does not accept on the
    // same edge that it frees a slot.
    assign w_push = in_valid && in_ready;
    assign w_pop  = !hold && !empty;
    assign w_head = r_mem[r_rd_ptr];

    // Storage needs no reset. The count decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_opcode, in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            a           <= '0;
            b           <= '0;
            opcode      <= '0;
            issue_valid <= 1'b0;
            issued_cnt  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end

            // a/b/opcode keep their last values when nothing issues.
            // Only issue_valid drops.
            issue_valid <= w_pop;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                opcode     <= w_head[c_pw-1 -: OPW];
                a          <= w_head[2*DW-1 -: DW];
                b          <= w_head[DW-1:0];
                issued_cnt <= issued_cnt + 8'd1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_fifo
// Description : Self-checking bench for alu_issue_fifo. It uses a queue-based
//               reference model, a table of hand-derived vectors, directed
//               corner sequences and randomized traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic [2:0] in_opcode = '0;
    logic       hold = 1'b0;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
    logic       issue_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic [7:0] issued_cnt;

    alu_issue_fifo #(.DW(4), .OPW(3), .DEPTH(4), .AW(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_opcode   (in_opcode),
        .hold        (hold),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .issue_valid (issue_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: a FIFO of {op,a,b} packets plus the issue registers.
    logic [10:0] m_q[$];
    logic [3:0]  m_a, m_b;
    logic [2:0]  m_op;
    logic        m_iv;
    logic [7:0]  m_ic;

    task automatic model_reset();
        m_q.delete();
        m_a = '0; m_b = '0; m_op = '0; m_iv = 1'b0; m_ic = '0;
    endtask

    task automatic check_model();
        chk("a", int'(a), int'(m_a));
        chk("b", int'(b), int'(m_b));
        chk("opcode", int'(opcode), int'(m_op));
        chk("issue_valid", int'(issue_valid), int'(m_iv));
        chk("count", int'(count), m_q.size());
        chk("full", int'(full), int'(m_q.size() == 4));
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("issued_cnt", int'(issued_cnt), int'(m_ic));
    endtask

    // One cycle: drive at negedge, check in_ready, advance model at posedge, check.
    task automatic step(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                        input logic [2:0] op, input logic h);
        logic do_push, do_pop;
        logic [10:0] pk;
        @(negedge clk);
        in_valid = v; in_a = ia; in_b = ib; in_opcode = op; hold = h;
        #1;
        chk("in_ready", int'(in_ready), int'(m_q.size() < 4));
        do_push = v && (m_q.size() < 4);
        do_pop  = !h && (m_q.size() > 0);
        @(posedge clk);
        if (do_pop) begin
            pk = m_q.pop_front();
            m_op = pk[10:8]; m_a = pk[7:4]; m_b = pk[3:0];
            m_iv = 1'b1; m_ic = m_ic + 8'd1;
        end else begin
            m_iv = 1'b0;
        end
        if (do_push) m_q.push_back({op, ia, ib});
        #1;
        check_model();
    endtask

    typedef struct {
        logic       v;
        logic [3:0] ia;
        logic [3:0] ib;
        logic [2:0] iop;
        logic       h;
        logic       rdy;
        logic       iv;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [2:0] eop;
        int         cnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int ivn;
        logic [7:0] ic0;
        logic pend;
        logic [3:0] ra, rb;
        logic [2:0] rop;
        logic rv, rh;

        // Single push/issue, then fill to full under hold and drain.
        tbl[0]  = '{1'b1, 4'hA, 4'h5, 3'd0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 3'd0, 1};
        tbl[1]  = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1, 4'hA, 4'h5, 3'd0, 0};
        tbl[2]  = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 4'hA, 4'h5, 3'd0, 0};
        tbl[3]  = '{1'b1, 4'h1, 4'h2, 3'd1, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5, 3'd0, 1};
        tbl[4]  = '{1'b1, 4'h3, 4'h4, 3'd2, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5, 3'd0, 2};
        tbl[5]  = '{1'b1, 4'h5, 4'h6, 3'd3, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5, 3'd0, 3};
        tbl[6]  = '{1'b1, 4'h7, 4'h8, 3'd4, 1'b1, 1'b1, 1'b0, 4'hA, 4'h5, 3'd0, 4};
        tbl[7]  = '{1'b1, 4'h9, 4'hA, 3'd5, 1'b1, 1'b0, 1'b0, 4'hA, 4'h5, 3'd0, 4};
        tbl[8]  = '{1'b1, 4'h9, 4'hA, 3'd5, 1'b0, 1'b0, 1'b1, 4'h1, 4'h2, 3'd1, 3};
        tbl[9]  = '{1'b1, 4'h9, 4'hA, 3'd5, 1'b0, 1'b1, 1'b1, 4'h3, 4'h4, 3'd2, 3};
        tbl[10] = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1, 4'h5, 4'h6, 3'd3, 2};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1, 4'h7, 4'h8, 3'd4, 1};
        tbl[12] = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1, 4'h9, 4'hA, 3'd5, 0};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 4'h9, 4'hA, 3'd5, 0};

        // Reset with random inputs toggling.
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'(($urandom)); hold = 1'($urandom);
            in_a = 4'($urandom); in_b = 4'($urandom); in_opcode = 3'($urandom);
        end
        #1;
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        chk("rst_opcode", int'(opcode), 0);
        chk("rst_issue_valid", int'(issue_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_issued_cnt", int'(issued_cnt), 0);
        @(negedge clk);
        in_valid = 1'b0; hold = 1'b0;
        rst = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v; in_a = tbl[i].ia; in_b = tbl[i].ib;
            in_opcode = tbl[i].iop; hold = tbl[i].h;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), int'(in_ready), int'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_issue_valid", i), int'(issue_valid), int'(tbl[i].iv));
            chk($sformatf("tbl%0d_a", i), int'(a), int'(tbl[i].ea));
            chk($sformatf("tbl%0d_b", i), int'(b), int'(tbl[i].eb));
            chk($sformatf("tbl%0d_opcode", i), int'(opcode), int'(tbl[i].eop));
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
        end
        chk("tbl_issued_cnt", int'(issued_cnt), 6);

        // Bring the model in line with the table's end state.
        m_q.delete();
        m_a = 4'h9; m_b = 4'hA; m_op = 3'd5; m_iv = 1'b0; m_ic = 8'd6;

        // Streaming: one push per cycle with no hold.
        ic0 = m_ic;
        ivn = 0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) step(1'b1, 4'(i), 4'(15 - i), 3'(i), 1'b0);
            else       step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
            if (issue_valid) ivn++;
            if (i < 8) chk("stream_count", int'(count), 1);
        end
        chk("stream_issues", ivn, 8);
        chk("stream_issued_cnt", int'(issued_cnt), int'(ic0 + 8'd8));

        // Random traffic with hold toggling. It crosses many pointer wraps and
        // the issued_cnt wrap. A refused packet stays stable until accepted.
        pend = 1'b0; ra = '0; rb = '0; rop = '0;
        for (int i = 0; i < 900; i++) begin
            rv = pend ? 1'b1 : ($urandom_range(0, 99) < 75);
            if (!pend) begin
                ra = 4'($urandom); rb = 4'($urandom); rop = 3'($urandom);
            end
            rh = ($urandom_range(0, 99) < 30);
            pend = rv && (m_q.size() == 4);
            step(rv, ra, rb, rop, rh);
        end

        // Mid-cycle async reset with packets queued under hold.
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 3), 4'(i + 7), 3'(i + 1), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_issue_valid", int'(issue_valid), 0);
        chk("midrst_a", int'(a), 0);
        chk("midrst_b", int'(b), 0);
        chk("midrst_opcode", int'(opcode), 0);
        chk("midrst_empty", int'(empty), 1);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_issued_cnt", int'(issued_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
